// File: rtl/multi_mode_shift_reg_pkg.sv
// shift_reg_pkg: mode encodings and burst FSM state constants for multi_mode_shift_reg
// No ports; imported by the interface, the burst controller and the top.
package shift_reg_pkg;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;
    typedef logic state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;
endpackage

// File: rtl/multi_mode_shift_reg_if.sv
// multi_mode_shift_reg_if: control/data bundle between a driver (master) and the shift register (slave)
// Signals: enable, mode, start, parallel_in, sl_in, sr_in (master -> slave);
//          parallel_out, serial_out, busy, done (slave -> master).
// Optional: MULTI_MODE_SHIFT_REG_PARITY_EN adds parity_out (slave -> master).
interface multi_mode_shift_reg_if #(
    parameter int N = 8,
    parameter int W = 1
);
    logic         enable;
    logic [2:0]   mode;
    logic         start;
    logic [N-1:0] parallel_in;
    logic [W-1:0] sl_in;
    logic [W-1:0] sr_in;
    logic [N-1:0] parallel_out;
    logic [W-1:0] serial_out;
    logic         busy;
    logic         done;
`ifdef MULTI_MODE_SHIFT_REG_PARITY_EN
    logic         parity_out;
`endif
    modport master (
        output enable, mode, start, parallel_in, sl_in, sr_in,
        input  parallel_out, serial_out, busy, done
`ifdef MULTI_MODE_SHIFT_REG_PARITY_EN
        , input parity_out
`endif
    );
    modport slave (
        input  enable, mode, start, parallel_in, sl_in, sr_in,
        output parallel_out, serial_out, busy, done
`ifdef MULTI_MODE_SHIFT_REG_PARITY_EN
        , output parity_out
`endif
    );
endinterface

// File: rtl/multi_mode_shift_reg_burst_ctrl.sv
// shift_burst_ctrl: IDLE/SHIFT burst sequencer owning state, step count and the done pulse
// Ports: clock, reset (async, active-high), i_enable, i_start in;
//        o_load (accept burst, load register), o_shift (burst shift step), o_busy, o_done out.
module shift_burst_ctrl
    import shift_reg_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int CNT_W = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_enable,
    input  logic i_start,
    output logic o_load,
    output logic o_shift,
    output logic o_busy,
    output logic o_done
);
    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    assign o_busy  = (r_state == ST_SHIFT);
    assign o_done  = r_done;
    assign o_load  = i_enable && !o_busy && i_start;
    assign o_shift = i_enable && o_busy;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse; a frozen cycle also clears it
            r_done <= 1'b0;
            if (o_load) begin
                r_state <= ST_SHIFT;
                r_count <= CNT_W'(STEPS);
            end else if (o_shift) begin
                r_count <= r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/multi_mode_shift_reg.sv
// multi_mode_shift_reg: N-bit universal shift register (W bits/step) with autonomous burst serializer
// Ports: clock, reset (async, active-high); bus (slave modport of multi_mode_shift_reg_if):
//   in  enable, mode[2:0], start, parallel_in[N-1:0], sl_in[W-1:0], sr_in[W-1:0]
//   out parallel_out[N-1:0], serial_out[W-1:0], busy, done
// Optional: MULTI_MODE_SHIFT_REG_PARITY_EN adds bus.parity_out, registered even parity of the register.
module multi_mode_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    multi_mode_shift_reg_if.slave bus
);
    localparam int STEPS = N / W;
    localparam int CNT_W = $clog2(STEPS + 1);
    logic [N-1:0] r_reg;
    logic [N-1:0] w_reg_nxt;
    logic [W-1:0] r_sout;
    logic [W-1:0] w_sout_nxt;
    logic         w_load;
    logic         w_shift;
    logic         w_busy;
    logic         w_done;
    generate
        if (N < 2 || W < 1 || W >= N || (N % W) != 0) begin : g_bad_params
            $error("multi_mode_shift_reg: need N >= 2, 1 <= W < N and N %% W == 0");
        end
    endgenerate
    shift_burst_ctrl #(
        .STEPS (STEPS),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clock    (clock),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_start  (bus.start),
        .o_load   (w_load),
        .o_shift  (w_shift),
        .o_busy   (w_busy),
        .o_done   (w_done)
    );
    // Burst start outranks mode; during a burst mode is ignored
    always_comb begin
        w_reg_nxt  = r_reg;
        w_sout_nxt = r_sout;
        if (w_load) begin
            w_reg_nxt = bus.parallel_in;
        end else if (w_shift) begin
            w_sout_nxt = r_reg[W-1:0];
            w_reg_nxt  = {bus.sr_in, r_reg[N-1:W]};
        end else if (!w_busy) begin
            case (bus.mode)
                MODE_SHL: begin
                    w_sout_nxt = r_reg[N-1:N-W];
                    w_reg_nxt  = {r_reg[N-W-1:0], bus.sl_in};
                end
                MODE_SHR: begin
                    w_sout_nxt = r_reg[W-1:0];
                    w_reg_nxt  = {bus.sr_in, r_reg[N-1:W]};
                end
                MODE_LOAD: w_reg_nxt = bus.parallel_in;
                MODE_ROTL: begin
                    w_sout_nxt = r_reg[N-1:N-W];
                    w_reg_nxt  = {r_reg[N-W-1:0], r_reg[N-1:N-W]};
                end
                MODE_ROTR: begin
                    w_sout_nxt = r_reg[W-1:0];
                    w_reg_nxt  = {r_reg[W-1:0], r_reg[N-1:W]};
                end
                MODE_ASHR: begin
                    w_sout_nxt = r_reg[W-1:0];
                    w_reg_nxt  = {{W{r_reg[N-1]}}, r_reg[N-1:W]};
                end
                MODE_HOLD, MODE_RSVD: ;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_reg  <= '0;
            r_sout <= '0;
        end else if (bus.enable) begin
            r_reg  <= w_reg_nxt;
            r_sout <= w_sout_nxt;
        end
    end
    assign bus.parallel_out = r_reg;
    assign bus.serial_out   = r_sout;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
`ifdef MULTI_MODE_SHIFT_REG_PARITY_EN
    logic r_par;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_par <= 1'b0;
        else if (bus.enable) r_par <= ^w_reg_nxt;
    end
    assign bus.parity_out = r_par;
`endif
endmodule

// File: tb/tb_multi_mode_shift_reg.sv
// tb_multi_mode_shift_reg: scoreboard bench driving an N=8/W=1 and an N=8/W=2 instance in lockstep
module tb_multi_mode_shift_reg;
    import shift_reg_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    multi_mode_shift_reg_if #(.N(8), .W(1)) if_a ();
    multi_mode_shift_reg_if #(.N(8), .W(2)) if_b ();
    multi_mode_shift_reg #(.N(8), .W(1)) u_a (.clock(clock), .reset(reset), .bus(if_a));
    multi_mode_shift_reg #(.N(8), .W(2)) u_b (.clock(clock), .reset(reset), .bus(if_b));
    typedef struct packed {
        logic [7:0] p0, p1;
        logic [1:0] s0, s1;
        logic       b0, b1, d0, d1, y0, y1;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] m_reg[2];
    logic [1:0] m_sout[2];
    logic       m_done[2];
    int         m_rem[2];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: register as an integer, shifts as plain arithmetic on the spec's rules
    task automatic model(input int id, input int w, input logic en, input logic st,
                         input logic [2:0] md, input logic [7:0] pin, input logic [1:0] sl, input logic [1:0] sr);
        int r, msk, s;
        r = m_reg[id];
        s = m_sout[id];
        msk = (1 << w) - 1;
        m_done[id] = 1'b0;
        if (!en) return;
        if (m_rem[id] > 0) begin
            s = r & msk;
            r = (r >> w) | ((sr & msk) << (8 - w));
            m_rem[id]--;
            m_done[id] = (m_rem[id] == 0);
        end else if (st) begin
            r = pin;
            m_rem[id] = 8 / w;
        end else begin
            case (md)
                3'd1: begin s = r >> (8 - w); r = (r << w) | (sl & msk); end
                3'd2: begin s = r & msk; r = (r >> w) | ((sr & msk) << (8 - w)); end
                3'd3: r = pin;
                3'd4: begin s = r >> (8 - w); r = (r << w) | (r >> (8 - w)); end
                3'd5: begin s = r & msk; r = (r >> w) | ((r & msk) << (8 - w)); end
                3'd6: begin s = r & msk; r = (r >> w) | (((r & 8'h80) != 0) ? (msk << (8 - w)) : 0); end
                default: ;
            endcase
        end
        m_reg[id]  = 8'(r);
        m_sout[id] = 2'(s);
    endtask

    task automatic step(input logic en, input logic st, input logic [2:0] md,
                        input logic [7:0] pin, input logic [1:0] sl, input logic [1:0] sr);
        exp_t e;
        @(negedge clock);
        if_a.enable = en; if_a.start = st; if_a.mode = md; if_a.parallel_in = pin;
        if_a.sl_in = sl[0]; if_a.sr_in = sr[0];
        if_b.enable = en; if_b.start = st; if_b.mode = md; if_b.parallel_in = pin;
        if_b.sl_in = sl; if_b.sr_in = sr;
        model(0, 1, en, st, md, pin, {1'b0, sl[0]}, {1'b0, sr[0]});
        model(1, 2, en, st, md, pin, sl, sr);
        e.p0 = m_reg[0]; e.p1 = m_reg[1];
        e.s0 = m_sout[0]; e.s1 = m_sout[1];
        e.b0 = m_rem[0] > 0; e.b1 = m_rem[1] > 0;
        e.d0 = m_done[0]; e.d1 = m_done[1];
        e.y0 = ^m_reg[0]; e.y1 = ^m_reg[1];
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, MODE_HOLD, 8'h00, 2'b00, 2'b00);
    endtask

    // Reset asserted between edges must clear outputs at once
    task automatic do_reset(input string nm);
        @(negedge clock);
        #1;
        reset = 1'b1;
        if_a.enable = 1'b0; if_a.start = 1'b0;
        if_b.enable = 1'b0; if_b.start = 1'b0;
        #1;
        chk({nm, "_pout_a"}, if_a.parallel_out, 8'h00);
        chk({nm, "_sout_a"}, 8'(if_a.serial_out), 8'h00);
        chk({nm, "_busy_a"}, 8'(if_a.busy), 8'h00);
        chk({nm, "_done_a"}, 8'(if_a.done), 8'h00);
        chk({nm, "_pout_b"}, if_b.parallel_out, 8'h00);
        chk({nm, "_sout_b"}, 8'(if_b.serial_out), 8'h00);
        chk({nm, "_busy_b"}, 8'(if_b.busy), 8'h00);
        chk({nm, "_done_b"}, 8'(if_b.done), 8'h00);
`ifdef MULTI_MODE_SHIFT_REG_PARITY_EN
        chk({nm, "_par_a"}, 8'(if_a.parity_out), 8'h00);
        chk({nm, "_par_b"}, 8'(if_b.parity_out), 8'h00);
`endif
        for (int i = 0; i < 2; i++) begin
            m_reg[i] = '0; m_sout[i] = '0; m_done[i] = 1'b0; m_rem[i] = 0;
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pout_a", if_a.parallel_out, e.p0);
                chk("sout_a", 8'(if_a.serial_out), 8'(e.s0[0]));
                chk("busy_a", 8'(if_a.busy), 8'(e.b0));
                chk("done_a", 8'(if_a.done), 8'(e.d0));
                chk("pout_b", if_b.parallel_out, e.p1);
                chk("sout_b", 8'(if_b.serial_out), 8'(e.s1));
                chk("busy_b", 8'(if_b.busy), 8'(e.b1));
                chk("done_b", 8'(if_b.done), 8'(e.d1));
`ifdef MULTI_MODE_SHIFT_REG_PARITY_EN
                chk("par_a", 8'(if_a.parity_out), 8'(e.y0));
                chk("par_b", 8'(if_b.parity_out), 8'(e.y1));
`endif
            end
        end
    end

    initial begin : stimulus
        if_a.enable = 1'b0; if_a.start = 1'b0; if_a.mode = '0; if_a.parallel_in = '0; if_a.sl_in = '0; if_a.sr_in = '0;
        if_b.enable = 1'b0; if_b.start = 1'b0; if_b.mode = '0; if_b.parallel_in = '0; if_b.sl_in = '0; if_b.sr_in = '0;
        do_reset("rst_init");
        // Reset mid-burst with register = A5 and a non-zero serial_out
        step(1'b1, 1'b0, MODE_LOAD, 8'h03, 2'b00, 2'b00);
        step(1'b1, 1'b0, MODE_SHR, 8'h00, 2'b00, 2'b00);
        step(1'b1, 1'b1, MODE_HOLD, 8'hA5, 2'b00, 2'b00);
        settle();
        chk("t1_pre_a", if_a.parallel_out, 8'hA5);
        do_reset("t1_rst");
        // shl then ashr on the W=1 instance
        step(1'b1, 1'b0, MODE_LOAD, 8'h96, 2'b00, 2'b00);
        step(1'b1, 1'b0, MODE_SHL, 8'h00, 2'b01, 2'b00);
        settle();
        chk("t2_shl_p", if_a.parallel_out, 8'h2D);
        chk("t2_shl_s", 8'(if_a.serial_out), 8'h01);
        step(1'b1, 1'b0, MODE_ASHR, 8'h00, 2'b00, 2'b00);
        settle();
        chk("t2_ashr_p", if_a.parallel_out, 8'h16);
        chk("t2_ashr_s", 8'(if_a.serial_out), 8'h01);
        // rotr twice on the W=2 instance
        step(1'b1, 1'b0, MODE_LOAD, 8'hC3, 2'b00, 2'b00);
        step(1'b1, 1'b0, MODE_ROTR, 8'h00, 2'b00, 2'b00);
        settle();
        chk("t3_rotr1_p", if_b.parallel_out, 8'hF0);
        chk("t3_rotr1_s", 8'(if_b.serial_out), 8'h03);
        step(1'b1, 1'b0, MODE_ROTR, 8'h00, 2'b00, 2'b00);
        settle();
        chk("t3_rotr2_p", if_b.parallel_out, 8'h3C);
        chk("t3_rotr2_s", 8'(if_b.serial_out), 8'h00);
        // W=2 burst of E4: chunks 0,1,2,3 with done on the last
        step(1'b1, 1'b1, MODE_HOLD, 8'hE4, 2'b00, 2'b00);
        settle();
        chk("t4_busy0", 8'(if_b.busy), 8'h01);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            settle();
            chk("t4_chunk", 8'(if_b.serial_out), 8'(k));
            chk("t4_done", 8'(if_b.done), 8'(k == 3));
            chk("t4_busy", 8'(if_b.busy), 8'(k < 3));
        end
        chk("t4_final", if_b.parallel_out, 8'h00);
        idle(5);
        // W=1 burst with enable dropped three cycles mid-burst
        step(1'b1, 1'b1, MODE_HOLD, 8'h6B, 2'b00, 2'b01);
        idle(3);
        repeat (3) begin
            step(1'b0, 1'b0, MODE_HOLD, 8'h00, 2'b00, 2'b00);
            settle();
            chk("t5_frozen_done", 8'(if_a.done), 8'h00);
            chk("t5_frozen_busy", 8'(if_a.busy), 8'h01);
        end
        idle(4);
        settle();
        chk("t5_not_yet", 8'(if_a.done), 8'h00);
        idle(1);
        settle();
        chk("t5_done", 8'(if_a.done), 8'h01);
        idle(2);
        // start beats mode; start on the final burst edge is ignored
        step(1'b1, 1'b1, MODE_SHL, 8'h5A, 2'b01, 2'b00);
        settle();
        chk("t6_load", if_a.parallel_out, 8'h5A);
        chk("t6_busy", 8'(if_a.busy), 8'h01);
        repeat (7) step(1'b1, 1'b0, MODE_SHL, 8'h00, 2'b01, 2'b01);
        step(1'b1, 1'b1, MODE_HOLD, 8'h77, 2'b00, 2'b00);
        settle();
        chk("t6_last_done", 8'(if_a.done), 8'h01);
        chk("t6_last_busy", 8'(if_a.busy), 8'h00);
        idle(1);
        settle();
        chk("t6_after_busy", 8'(if_a.busy), 8'h00);
        idle(4);
        // Randomised traffic against the reference model, with one reset mid-stream
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                 8'($urandom), 2'($urandom), 2'($urandom));
            if (i == 200) begin
                settle();
                do_reset("rnd_rst");
            end
        end
        settle();
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_mode_shift_reg.md
Name: multi_mode_shift_reg

Overview:
- Parametrised universal shift register, N bits wide, shifting W bits (one lane chunk) per step.
- Modes: hold, logical shift left/right, parallel load, rotate left/right, arithmetic shift right.
- Adds an autonomous burst serializer: one start pulse loads parallel_in and shifts it out W bits per enabled cycle, with busy/done status.
- Used as a general datapath/serial-link building block.

Parameters:
- N, 8, register width in bits; N >= 2.
- W, 1, bits shifted per step; 1 <= W < N; N % W == 0, else elaboration error.
- STEPS (localparam), N/W, shift steps per burst.
- CNT_W (localparam), $clog2(STEPS+1), burst counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  clock enable; low = all state frozen.
- mode  in  3  operation select, IDLE state only.
- start  in  1  burst request, sampled in IDLE with enable high.
- parallel_in  in  N  load / burst data.
- sl_in  in  W  fill chunk for shift left.
- sr_in  in  W  fill chunk for logical shift right and burst shifts.
- parallel_out  out  N  current register contents (direct, no extra latency).
- serial_out  out  W  registered: last chunk shifted or rotated out.
- busy  out  1  high while in SHIFT state.
- done  out  1  one-cycle pulse marking the final burst chunk.

Behaviour:
- Reset (async, active-high): register = 0, serial_out = 0, count = 0, state = IDLE, busy = 0, done = 0. Reset mid-burst aborts it with no done pulse.
- All updates occur on the rising edge of clock when enable = 1.
- enable = 0: register, serial_out, count and state hold; done is forced to 0. A pulse is never stretched.
- done defaults to 0 on every enabled edge unless set by the final burst step.
- State IDLE, start = 1 (start has priority over mode):
  - register <= parallel_in; count <= STEPS; state <= SHIFT.
  - serial_out is unchanged.
- State IDLE, start = 0, mode encoding:
  - 000 hold.
  - 001 shl: serial_out <= reg[N-1:N-W]; reg <= {reg[N-W-1:0], sl_in}.
  - 010 shr: serial_out <= reg[W-1:0]; reg <= {sr_in, reg[N-1:W]}.
  - 011 load: reg <= parallel_in; serial_out is unchanged.
  - 100 rotl: serial_out <= reg[N-1:N-W]; reg <= {reg[N-W-1:0], reg[N-1:N-W]}.
  - 101 rotr: serial_out <= reg[W-1:0]; reg <= {reg[W-1:0], reg[N-1:W]}.
  - 110 ashr: serial_out <= reg[W-1:0]; reg <= {{W{reg[N-1]}}, reg[N-1:W]}.
  - 111 reserved; behaves as hold.
- State SHIFT (mode and start ignored):
  - Each enabled cycle: serial_out <= reg[W-1:0]; reg <= {sr_in, reg[N-1:W]}; count <= count - 1.
  - When count == 1: state <= IDLE and done <= 1. done and the final chunk appear in the same cycle.
- busy = (state == SHIFT), combinational from the state register.
- Burst latency: start accepted at edge 0; chunk k (LSB chunk first) is valid on serial_out after edge k, for k = 1..STEPS. done is high after edge STEPS.
- A start that is high on the same edge SHIFT returns to IDLE is ignored. A new start is accepted no earlier than the following enabled edge.
- No combinational path from inputs to any output other than parallel_out/busy, which are driven from registers.

Optional Feature:
- Macro: MULTI_MODE_SHIFT_REG_PARITY_EN.
- Defined: adds output parity_out (1 bit).
  - Registered even parity (XOR-reduce) of the register value after each enabled update.
  - Reset value 0.
  - Frozen when enable = 0.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package shift_reg_pkg holds:
  - mode encoding constants: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR, MODE_ASHR, MODE_RSVD.
  - state typedef: ST_IDLE, ST_SHIFT.
- One sub-module, shift_burst_ctrl, owns:
  - the state, count and done logic.
  - outputs to the datapath: a load strobe and a shift strobe.
- The datapath stays in the top module.

Test Plan:
1. N=8, W=1: reset asserted mid-operation with reg=8'hA5 -> parallel_out, serial_out, busy, done all 0 immediately, without waiting for a clock edge.
2. N=8, W=1: load 8'h96, then mode shl with sl_in=1 -> parallel_out=8'h2D, serial_out=1. Then ashr -> 8'h16, serial_out=1.
3. N=8, W=2: load 8'hC3, then rotr twice -> 8'hF0 then 8'h3C; serial_out 2'b11 then 2'b00.
4. N=8, W=2: start with parallel_in=8'hE4, sr_in=0 -> serial_out 0,1,2,3 (one chunk per cycle); busy high for 4 cycles; done high with chunk 3 only; parallel_out ends 8'h00.
5. N=8, W=1: start burst, drop enable for 3 cycles mid-burst -> serial_out/count frozen, done held low. Completion is delayed by exactly 3 cycles.
6. With start and mode=shl both high in IDLE -> load taken, shift ignored. With start high on the final burst edge -> ignored, busy stays low next cycle.
